gf22_sram_1w1r_wbuf: RTL and testbench

GF22_SRAM_1W1R_WBUF -- requirements
Module: gf22_sram_1w1r_wbuf

---
 rtl/gf22_sram_1w1r_wbuf_if.sv | 24 ++
 rtl/gf22_sram_1w1r_wbuf.sv | 157 +++++++++++++++
 tb/tb_gf22_sram_1w1r_wbuf.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gf22_sram_1w1r_wbuf_if.sv
// Write/read request bus for the banked 1W1R SRAM wrapper with write buffer.
interface gf22_sram_1w1r_wbuf_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13
);
  logic              WVALID;
  logic              WREADY;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] WEM;
  logic              RVALID;
  logic [ADDR_W-1:0] RA;
  logic              RDVALID;
  logic [DATA_W-1:0] RDATA;

  modport master (
    output WVALID, WA, WD, WEM, RVALID, RA,
    input  WREADY, RDVALID, RDATA
  );
  modport slave (
    input  WVALID, WA, WD, WEM, RVALID, RA,
    output WREADY, RDVALID, RDATA
  );
endinterface

// File: rtl/gf22_sram_1w1r_wbuf.sv
// Banked single-port SRAM presenting 1W1R: reads always win, writes park in an in-order buffer.
// Define GF22_SRAM_FWD_EN to merge buffered writes into read data.
module gf22_sram_bank #(
  parameter int DATA_W = 64,
  parameter int AW     = 11
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] wm,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge CLK)
    if (en && we) mem[addr] <= (mem[addr] & ~wm) | (wd & wm);

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN)           q <= '0;
    else if (en && !we)  q <= mem[addr];
endmodule

module gf22_sram_1w1r_wbuf #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 13,
  parameter int NBANKS     = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic CLK,
  input  logic RSTN,
  gf22_sram_1w1r_wbuf_if.slave bus
);
  localparam int BW = $clog2(NBANKS);
  localparam int LW = ADDR_W - BW;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] m;
  } wreq_t;

  wreq_t               wb [WBUF_DEPTH];
  logic [PW-1:0]       head, tail;
  logic [CW-1:0]       cnt;
  wreq_t               hd, wr_in, wsel;
  logic                empty, full, acc, pop, byp, push, wr_any;
  logic [BW-1:0]       rbank, hbank, wbank, wr_bank;
  logic [NBANKS-1:0][DATA_W-1:0] bq;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign hd      = wb[head];
  assign wr_in   = {bus.WA, bus.WD, bus.WEM};
  assign rbank   = bus.RA[BW-1:0];
  assign hbank   = hd.a[BW-1:0];
  assign wbank   = bus.WA[BW-1:0];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(WBUF_DEPTH));
  assign bus.WREADY = !full;
  assign acc     = bus.WVALID && !full;
  // Bypass only into an empty buffer so retirement order always matches acceptance order.
  assign pop     = !empty && !(bus.RVALID && rbank == hbank);
  assign byp     = acc && empty && !(bus.RVALID && rbank == wbank);
  assign push    = acc && !byp;
  assign wsel    = pop ? hd : wr_in;
  assign wr_any  = pop || byp;
  assign wr_bank = wsel.a[BW-1:0];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic rd_b, wr_b;
    assign rd_b = bus.RVALID && (rbank == BW'(b));
    assign wr_b = wr_any && (wr_bank == BW'(b));
    gf22_sram_bank #(.DATA_W(DATA_W), .AW(LW)) u_bank (
      .CLK  (CLK),
      .RSTN (RSTN),
      .en   (rd_b || wr_b),
      .we   (wr_b && !rd_b),
      .addr (rd_b ? bus.RA[ADDR_W-1:BW] : wsel.a[ADDR_W-1:BW]),
      .wd   (wsel.d),
      .wm   (wsel.m),
      .q    (bq[b])
    );
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      cnt <= cnt + CW'(push) - CW'(pop);
    end

  always_ff @(posedge CLK)
    if (push) wb[tail] <= wr_in;

  logic          rdv_q;
  logic [BW-1:0] rsel_q;

`ifdef GF22_SRAM_FWD_EN
  logic [DATA_W-1:0] fd, fm, fd_q, fm_q;
  logic [PW-1:0]     idx;

  // Walk oldest to youngest so later writes overwrite earlier ones bit by bit.
  always_comb begin
    fd  = '0;
    fm  = '0;
    idx = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = PW'((int'(head) + i) % WBUF_DEPTH);
      if (CW'(i) < cnt && wb[idx].a == bus.RA) begin
        fd = (fd & ~wb[idx].m) | (wb[idx].d & wb[idx].m);
        fm = fm | wb[idx].m;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      rdv_q  <= 1'b0;
      rsel_q <= '0;
      fd_q   <= '0;
      fm_q   <= '0;
    end else begin
      rdv_q <= bus.RVALID;
      if (bus.RVALID) begin
        rsel_q <= rbank;
        fd_q   <= fd;
        fm_q   <= fm;
      end
    end

  assign bus.RDATA = (bq[rsel_q] & ~fm_q) | (fd_q & fm_q);
`else
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      rdv_q  <= 1'b0;
      rsel_q <= '0;
    end else begin
      rdv_q <= bus.RVALID;
      if (bus.RVALID) rsel_q <= rbank;
    end

  assign bus.RDATA = bq[rsel_q];
`endif

  assign bus.RDVALID = rdv_q;
endmodule

// File: tb/tb_gf22_sram_1w1r_wbuf.sv
// Bench for gf22_sram_1w1r_wbuf: vector table plus hand sequences, read data via a scoreboard queue.
module tb_gf22_sram_1w1r_wbuf;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  gf22_sram_1w1r_wbuf_if #(.DATA_W(64), .ADDR_W(13)) ifc ();

  gf22_sram_1w1r_wbuf #(.DATA_W(64), .ADDR_W(13), .NBANKS(4), .WBUF_DEPTH(4)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (ifc)
  );

  typedef struct {
    bit          wv;
    logic [12:0] wa;
    logic [63:0] wd;
    logic [63:0] wem;
    bit          rv;
    logic [12:0] ra;
    bit          ew;
    logic [63:0] er;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] P11  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P55  = 64'h5555_5555_5555_5555;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];
  logic [63:0] last_rd = '0;
  vec_t vt [$];
  logic [63:0] wdat [5];
  logic [12:0] wadr [5];
  logic [63:0] fwd_a, fwd_b;

  function automatic vec_t mk(bit wv, logic [12:0] wa, logic [63:0] wd, logic [63:0] wem,
                              bit rv, logic [12:0] ra, bit ew, logic [63:0] er);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.wem = wem;
    v.rv = rv; v.ra = ra; v.ew = ew; v.er = er;
    return v;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic step(input vec_t v, input string tag);
    ifc.WVALID = v.wv; ifc.WA = v.wa; ifc.WD = v.wd; ifc.WEM = v.wem;
    ifc.RVALID = v.rv; ifc.RA = v.ra;
    chk({tag, " wready"}, {63'd0, ifc.WREADY}, {63'd0, v.ew});
    if (v.rv) sb.push_back(v.er);
    @(posedge CLK);
    #1;
    chk({tag, " rdvalid"}, {63'd0, ifc.RDVALID}, {63'd0, v.rv});
    if (ifc.RDVALID) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL %s rdata: response with empty scoreboard", tag);
      end else begin
        last_rd = sb.pop_front();
        chk({tag, " rdata"}, ifc.RDATA, last_rd);
      end
    end else begin
      chk({tag, " rdata hold"}, ifc.RDATA, last_rd);
    end
  endtask

  function automatic vec_t idle(bit ew);
    return mk(0, 13'h0, 64'h0, 64'h0, 0, 13'h0, ew, 64'h0);
  endfunction

  initial begin
    wadr[0] = 13'h011; wadr[1] = 13'h015; wadr[2] = 13'h019; wadr[3] = 13'h01D; wadr[4] = 13'h011;
    for (int k = 0; k < 5; k++) wdat[k] = 64'hC0DE_0000_0000_0000 | 64'(k + 1);

    // Bypass write then read back; simultaneous read/write to different banks.
    vt.push_back(mk(1, 13'h004, PAA, ONES, 0, 13'h0, 1, 64'h0));
    vt.push_back(idle(1));
    vt.push_back(mk(0, 13'h0, 64'h0, 64'h0, 1, 13'h004, 1, PAA));
    vt.push_back(idle(1));
    vt.push_back(mk(1, 13'h008, P11, ONES, 0, 13'h0, 1, 64'h0));
    vt.push_back(mk(1, 13'h005, P55, ONES, 1, 13'h008, 1, P11));
    vt.push_back(mk(0, 13'h0, 64'h0, 64'h0, 1, 13'h005, 1, P55));
    // Ten reads to bank 1 block retirement: buffer fills, fifth write stalls.
    for (int k = 0; k < 10; k++) begin
      int w;
      w = (k < 4) ? k : 4;
      vt.push_back(mk(1, wadr[w], wdat[w], ONES, 1, 13'h005, (k < 4), P55));
    end
    vt.push_back(mk(1, wadr[4], wdat[4], ONES, 0, 13'h0, 0, 64'h0));
    vt.push_back(mk(1, wadr[4], wdat[4], ONES, 0, 13'h0, 1, 64'h0));
    for (int k = 0; k < 3; k++) vt.push_back(idle(1));
    vt.push_back(mk(0, 13'h0, 64'h0, 64'h0, 1, 13'h011, 1, wdat[4]));
    for (int k = 1; k < 4; k++)
      vt.push_back(mk(0, 13'h0, 64'h0, 64'h0, 1, wadr[k], 1, wdat[k]));
    vt.push_back(idle(1));

    ifc.WVALID = 0; ifc.WA = '0; ifc.WD = '0; ifc.WEM = '0; ifc.RVALID = 0; ifc.RA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset rdvalid", {63'd0, ifc.RDVALID}, 64'd0);
    chk("reset rdata", ifc.RDATA, 64'd0);
    chk("reset wready", {63'd0, ifc.WREADY}, 64'd1);
    RSTN = 1'b1;

    for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("vec%0d", i));

    // Two overlapping masked writes held in the buffer, then read of the same word.
`ifdef GF22_SRAM_FWD_EN
    fwd_a = 64'h0000_0000_0000_00FF;
    fwd_b = 64'h0000_0000_0000_12FF;
`else
    fwd_a = 64'h0;
    fwd_b = 64'h0;
`endif
    step(mk(1, 13'h009, 64'h0, ONES, 0, 13'h0, 1, 64'h0), "fwd init");
    step(mk(1, 13'h009, 64'hFFFF, 64'h00FF, 1, 13'h005, 1, P55), "fwd w1");
    step(mk(1, 13'h009, 64'h1200, 64'hFF00, 1, 13'h009, 1, fwd_a), "fwd w2 same-cycle read");
    step(mk(0, 13'h0, 64'h0, 64'h0, 1, 13'h009, 1, fwd_b), "fwd read");
    step(idle(1), "fwd drain1");
    step(idle(1), "fwd drain2");
    step(mk(0, 13'h0, 64'h0, 64'h0, 1, 13'h009, 1, 64'h12FF), "fwd after drain");
    step(idle(1), "fwd idle");

    // Reset with three buffered writes pending: they must vanish.
    for (int k = 1; k < 4; k++)
      step(mk(1, wadr[k], 64'hDEAD_BEEF_DEAD_BEEF, ONES, 1, 13'h005, 1, P55), $sformatf("rst buf%0d", k));
    RSTN = 1'b0;
    #1;
    chk("midrst rdvalid", {63'd0, ifc.RDVALID}, 64'd0);
    chk("midrst rdata", ifc.RDATA, 64'd0);
    chk("midrst wready", {63'd0, ifc.WREADY}, 64'd1);
    #1;
    RSTN = 1'b1;
    sb.delete();
    last_rd = '0;
    step(idle(1), "post rst idle1");
    step(idle(1), "post rst idle2");
    step(idle(1), "post rst idle3");
    for (int k = 1; k < 4; k++)
      step(mk(0, 13'h0, 64'h0, 64'h0, 1, wadr[k], 1, wdat[k]), $sformatf("post rst read%0d", k));
    step(idle(1), "final idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
